gate_bist: RTL and testbench
============================

// Module: gate_bist
// PURPOSE
//  Self-test sequencer for a 2-input, 6-output logic-gate block (and/or/nand/nor/xor/xnor).
//  Drives a/b through all four input combinations and samples the six gate outputs.
//  Compares each sample against a golden truth table and reports per-gate pass/fail.
//  Sits beside the gate block on silicon or FPGA; used for power-on check and lab bring-up.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles to wait after driving a/b before sampling (range 0..15)
//  NUM_PASSES     1  full 4-vector sweeps per start (range 1..15); fail results accumulate across sweeps
// PORTS
//  clk         in   1  single clock; all logic on rising edge
//  rst         in   1  synchronous, active-high reset
//  start       in   1  one-cycle request; accepted only in IDLE
//  a_o         out  1  stimulus to gate block input a
//  b_o         out  1  stimulus to gate block input b
//  gate_y      in   6  gate block outputs: [0]and [1]or [2]nand [3]nor [4]xor [5]xnor
//  busy        out  1  high from the cycle after start is accepted until DONE
//  done        out  1  one-cycle pulse when a run completes
//  pass        out  1  valid with done; held until next accepted start; 1 = fail_mask==0
//  fail_mask   out  6  sticky per-gate mismatch flags, bit order as gate_y
//  fail_vec    out  2  {a,b} of first mismatching vector; valid when fail_valid=1
//  fail_valid  out  1  set on first mismatch of a run
// BEHAVIOUR
//  - Reset: state=IDLE, a_o=b_o=0, busy=0, done=0, pass=0, fail_mask=0, fail_vec=0, fail_valid=0.
//  - FSM: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//  - IDLE: on start=1, clear fail_mask/fail_vec/fail_valid/pass, reset vec=0, pass_cnt=0, go DRIVE.
//  - DRIVE (1 cycle): register a_o=vec[1], b_o=vec[0]; load settle counter; go SETTLE
//    (skip straight to SAMPLE when SETTLE_CYCLES=0).
//  - SETTLE: hold a_o/b_o for SETTLE_CYCLES cycles, then SAMPLE.
//  - SAMPLE (1 cycle): mism = gate_y ^ golden(vec); fail_mask |= mism;
//    if mism!=0 and fail_valid==0: fail_vec=vec, fail_valid=1.
//    Then vec+1 (2-bit wrap 11->00); on wrap pass_cnt+1; after last vector of last pass go DONE, else DRIVE.
//  - Vector order per pass: 00, 01, 10, 11 ({a,b}).
//  - Golden: and=a&b, or=a|b, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
//  - DONE (1 cycle): done=1, busy=0, pass=(fail_mask==0); next cycle IDLE. a_o/b_o hold last vector.
//  - Latency: start accepted in cycle T -> done high in cycle T + 1 + NUM_PASSES*4*(SETTLE_CYCLES+2).
//  - Timing of busy: busy=1 in DRIVE/SETTLE/SAMPLE only.
//  - start while busy or in DONE: ignored, no effect on results.
//  - rst mid-run: immediate return to reset values; no done pulse; partial results discarded.
//  - gate_y is sampled only in SAMPLE; X/changes elsewhere are don't-care.
// STRUCTURE
//  - Shared package gate_bist_pkg: gate bit-index constants (G_AND..G_XNOR),
//    state encoding enum/localparams (IDLE, DRIVE, SETTLE, SAMPLE, DONE), golden function gate_golden_f(a,b) -> [5:0].
//  - One sub-module: gate_golden (combinational, {a,b} -> 6-bit expected), reusable by benches.
//  - Top holds FSM, 2-bit vec counter, 4-bit settle counter, 4-bit pass counter, result registers.
// TESTING  (SETTLE_CYCLES=2, NUM_PASSES=1 unless stated)
//  1 Correct gate model on gate_y, start at T -> done at T+17, pass=1, fail_mask=0, fail_valid=0.
//  2 xnor output wired as nor -> done, pass=0, fail_mask=6'b100000, fail_vec=2'b11.
//  3 or_y stuck-at-1 -> fail_mask=6'b000010, fail_vec=2'b00 (not overwritten by later vectors).
//  4 start pulsed again at T+5 while busy -> ignored; single done at T+17; a_o/b_o sequence 00,01,10,11.
//  5 rst asserted at T+9 -> next cycle IDLE, all outputs at reset values, no done; new start -> clean run.
//  6 NUM_PASSES=2, SETTLE_CYCLES=0, correct model -> done at T+17, 8 SAMPLE cycles, pass=1.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// ----------------------------------------------------------------------------
// gate_bist_pkg
// Shared definitions for the gate-block self-test sequencer:
//   - bit positions of each gate output within the 6-bit gate bus
//   - FSM state encoding
//   - gate_golden_f: reference truth table for a 2-input gate block
// No ports (package).
// ----------------------------------------------------------------------------
package gate_bist_pkg;

    localparam int NUM_GATES = 6;

    localparam int G_AND  = 0;
    localparam int G_OR   = 1;
    localparam int G_NAND = 2;
    localparam int G_NOR  = 3;
    localparam int G_XOR  = 4;
    localparam int G_XNOR = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic logic [NUM_GATES-1:0] gate_golden_f(input logic a, input logic b);
        logic [NUM_GATES-1:0] y;
        y         = '0;
        y[G_AND]  = a & b;
        y[G_OR]   = a | b;
        y[G_NAND] = ~(a & b);
        y[G_NOR]  = ~(a | b);
        y[G_XOR]  = a ^ b;
        y[G_XNOR] = ~(a ^ b);
        return y;
    endfunction

endpackage

// File: rtl/gate_bist_if.sv
// ----------------------------------------------------------------------------
// gate_bist_if
// Bundles the control handshake, gate-block stimulus/response and result
// signals of gate_bist.
//   start      host -> bist  one-cycle run request
//   a_o, b_o   bist -> gate  stimulus for gate inputs a and b
//   gate_y     gate -> bist  [0]and [1]or [2]nand [3]nor [4]xor [5]xnor
//   busy       bist -> host  run in progress
//   done       bist -> host  one-cycle completion pulse
//   pass       bist -> host  1 = no gate mismatched in the last run
//   fail_mask  bist -> host  sticky per-gate mismatch flags
//   fail_vec   bist -> host  {a,b} of the first mismatching vector
//   fail_valid bist -> host  a mismatch has been seen this run
// Modports: master = host/gate side, slave = the sequencer.
// ----------------------------------------------------------------------------
interface gate_bist_if;
    import gate_bist_pkg::*;

    logic                 start;
    logic                 a_o;
    logic                 b_o;
    logic [NUM_GATES-1:0] gate_y;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [NUM_GATES-1:0] fail_mask;
    logic [1:0]           fail_vec;
    logic                 fail_valid;

    modport master (
        output start, gate_y,
        input  a_o, b_o, busy, done, pass, fail_mask, fail_vec, fail_valid
    );

    modport slave (
        input  start, gate_y,
        output a_o, b_o, busy, done, pass, fail_mask, fail_vec, fail_valid
    );

endinterface

// File: rtl/gate_bist_golden.sv
// ----------------------------------------------------------------------------
// gate_golden
// Combinational reference model of the 2-input gate block.
//   ab  in  2  {a,b} input vector
//   y   out 6  expected outputs, bit order as gate_y
// ----------------------------------------------------------------------------
module gate_golden
    import gate_bist_pkg::*;
(
    input  logic [1:0]           ab,
    output logic [NUM_GATES-1:0] y
);

    assign y = gate_golden_f(ab[1], ab[0]);

endmodule

// File: rtl/gate_bist.sv
// ----------------------------------------------------------------------------
// gate_bist
// Self-test sequencer for a 2-input / 6-output gate block. Sweeps {a,b}
// through 00,01,10,11 for NUM_PASSES passes, waits SETTLE_CYCLES after each
// drive, samples gate_y, compares against the golden truth table and
// accumulates per-gate fail flags.
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of gate_bist_if (start, stimulus, response, results)
// Parameters:
//   SETTLE_CYCLES  0..15  wait cycles between drive and sample
//   NUM_PASSES     1..15  full sweeps per run
// ----------------------------------------------------------------------------
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1
)(
    input logic        clk,
    input logic        rst,
    gate_bist_if.slave bus
);

    // The counter is loaded with N-1 so SETTLE lasts exactly N cycles;
    // with N=0 SETTLE is bypassed entirely and the load value is unused.
    localparam logic [3:0] SETTLE_LOAD = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_PASS   = 4'(NUM_PASSES - 1);

    state_t               state;
    logic [1:0]           vec;
    logic [3:0]           settle_cnt;
    logic [3:0]           pass_cnt;
    logic                 a_r;
    logic                 b_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 pass_r;
    logic [NUM_GATES-1:0] fail_mask_r;
    logic [1:0]           fail_vec_r;
    logic                 fail_valid_r;

    logic [NUM_GATES-1:0] golden;
    logic [NUM_GATES-1:0] mism;
    logic [NUM_GATES-1:0] mask_next;
    logic                 last_vec;

    gate_golden u_golden (
        .ab (vec),
        .y  (golden)
    );

    assign mism      = bus.gate_y ^ golden;
    assign mask_next = fail_mask_r | mism;
    assign last_vec  = (vec == 2'b11) && (pass_cnt == LAST_PASS);

    // Sequencer FSM with all outputs registered. pass is computed from the
    // mask value being written on the final SAMPLE, so it is valid in the
    // same cycle as done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            vec          <= 2'b00;
            settle_cnt   <= 4'd0;
            pass_cnt     <= 4'd0;
            a_r          <= 1'b0;
            b_r          <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_mask_r  <= '0;
            fail_vec_r   <= 2'b00;
            fail_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        fail_mask_r  <= '0;
                        fail_vec_r   <= 2'b00;
                        fail_valid_r <= 1'b0;
                        pass_r       <= 1'b0;
                        vec          <= 2'b00;
                        pass_cnt     <= 4'd0;
                        busy_r       <= 1'b1;
                        state        <= DRIVE;
                    end
                end
                DRIVE: begin
                    a_r        <= vec[1];
                    b_r        <= vec[0];
                    settle_cnt <= SETTLE_LOAD;
                    state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    fail_mask_r <= mask_next;
                    // Only the first mismatching vector of a run is kept.
                    if ((mism != '0) && !fail_valid_r) begin
                        fail_vec_r   <= vec;
                        fail_valid_r <= 1'b1;
                    end
                    vec <= vec + 2'd1;
                    if (vec == 2'b11) begin
                        pass_cnt <= pass_cnt + 4'd1;
                    end
                    if (last_vec) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= (mask_next == '0);
                        state  <= DONE;
                    end else begin
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_o        = a_r;
    assign bus.b_o        = b_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.pass       = pass_r;
    assign bus.fail_mask  = fail_mask_r;
    assign bus.fail_vec   = fail_vec_r;
    assign bus.fail_valid = fail_valid_r;

endmodule

// File: tb/tb_gate_bist.sv
// ----------------------------------------------------------------------------
// tb_gate_bist
// Directed bench for gate_bist. dut_a uses SETTLE_CYCLES=2, NUM_PASSES=1 and
// a gate-block model with selectable faults; dut_b uses SETTLE_CYCLES=0,
// NUM_PASSES=2 with a fault-free gate model.
// ----------------------------------------------------------------------------
module tb_gate_bist;
    import gate_bist_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate_bist_if bus_a ();
    gate_bist_if bus_b ();

    gate_bist #(.SETTLE_CYCLES(2), .NUM_PASSES(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    gate_bist #(.SETTLE_CYCLES(0), .NUM_PASSES(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // 0 = healthy, 1 = xnor output wired as nor, 2 = or output stuck at 1
    int fault_mode = 0;
    int total      = 0;
    int bad        = 0;
    int samples_b  = 0;

    function automatic logic [5:0] gate_model(input logic a, input logic b, input int mode);
        logic [5:0] y;
        y = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
        if (mode == 1) y[5] = ~(a | b);
        if (mode == 2) y[1] = 1'b1;
        return y;
    endfunction

    assign bus_a.gate_y = gate_model(bus_a.a_o, bus_a.b_o, fault_mode);
    assign bus_b.gate_y = gate_model(bus_b.a_o, bus_b.b_o, 0);

    // Counts SAMPLE cycles of dut_b; sampled at the edge that ends each cycle.
    always @(posedge clk) begin
        if (dut_b.state == SAMPLE) samples_b++;
    end

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] snap_a();
        return 16'({bus_a.a_o, bus_a.b_o, bus_a.busy, bus_a.done, bus_a.pass,
                    bus_a.fail_valid, bus_a.fail_vec, bus_a.fail_mask});
    endfunction

    // Pulses start on dut_a for one cycle; returns at the negedge of cycle T+1.
    task automatic apply_stimulus();
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    // Full run on dut_a; cyc is the cycle offset from T at which done is seen.
    task automatic run_a(input bit repulse, input bit chk_vec, output int cyc);
        apply_stimulus();
        cyc = 1;
        check_output("busy_rise", 16'(bus_a.busy), 16'h1);
        while (bus_a.done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (repulse) bus_a.start = (cyc == 5);
            if (chk_vec && (cyc % 4 == 0) && cyc <= 16)
                check_output("vec_seq", 16'({bus_a.a_o, bus_a.b_o}), 16'(cyc / 4 - 1));
        end
        bus_a.start = 1'b0;
        check_output("done_cycle", 16'(cyc), 16'd17);
        check_output("busy_in_done", 16'(bus_a.busy), 16'h0);
    endtask

    initial begin
        int cyc;
        int done_seen;
        int busy_seen;
        int s0;

        rst          = 1'b1;
        bus_a.start  = 1'b0;
        bus_b.start  = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_a", snap_a(), 16'h0);
        check_output("reset_b", 16'({bus_b.busy, bus_b.done, bus_b.pass, bus_b.fail_mask}), 16'h0);
        rst = 1'b0;

        $display("[TB] healthy gate block");
        fault_mode = 0;
        run_a(1'b0, 1'b1, cyc);
        check_output("t1_pass", 16'(bus_a.pass), 16'h1);
        check_output("t1_mask", 16'(bus_a.fail_mask), 16'h00);
        check_output("t1_valid", 16'(bus_a.fail_valid), 16'h0);
        @(negedge clk);
        check_output("t1_done_pulse", 16'(bus_a.done), 16'h0);
        check_output("t1_pass_held", 16'(bus_a.pass), 16'h1);

        $display("[TB] xnor wired as nor");
        fault_mode = 1;
        run_a(1'b0, 1'b0, cyc);
        check_output("t2_pass", 16'(bus_a.pass), 16'h0);
        check_output("t2_mask", 16'(bus_a.fail_mask), 16'h20);
        check_output("t2_vec", 16'(bus_a.fail_vec), 16'h3);
        check_output("t2_valid", 16'(bus_a.fail_valid), 16'h1);
        repeat (3) @(negedge clk);
        check_output("t2_held", 16'({bus_a.pass, bus_a.fail_mask}), 16'h20);

        $display("[TB] or stuck at 1");
        fault_mode = 2;
        run_a(1'b0, 1'b0, cyc);
        check_output("t3_pass", 16'(bus_a.pass), 16'h0);
        check_output("t3_mask", 16'(bus_a.fail_mask), 16'h02);
        check_output("t3_vec", 16'(bus_a.fail_vec), 16'h0);
        check_output("t3_valid", 16'(bus_a.fail_valid), 16'h1);

        $display("[TB] start while busy and in done");
        fault_mode = 0;
        run_a(1'b1, 1'b1, cyc);
        check_output("t4_pass", 16'(bus_a.pass), 16'h1);
        check_output("t4_mask", 16'(bus_a.fail_mask), 16'h00);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        done_seen = 0;
        busy_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) done_seen++;
            if (bus_a.busy === 1'b1) busy_seen++;
        end
        check_output("t4_no_second_done", 16'(done_seen), 16'd0);
        check_output("t4_no_restart", 16'(busy_seen), 16'd0);
        check_output("t4_pass_held", 16'(bus_a.pass), 16'h1);

        $display("[TB] reset mid-run");
        fault_mode = 2;
        apply_stimulus();
        cyc = 1;
        done_seen = 0;
        while (cyc < 9) begin
            @(negedge clk);
            cyc++;
            if (bus_a.done === 1'b1) done_seen++;
            if (cyc == 8) check_output("t5_partial_valid", 16'(bus_a.fail_valid), 16'h1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("t5_reset_state", snap_a(), 16'h0);
        repeat (20) begin
            @(negedge clk);
            if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) done_seen++;
        end
        check_output("t5_no_done", 16'(done_seen), 16'd0);
        fault_mode = 0;
        run_a(1'b0, 1'b1, cyc);
        check_output("t5_clean_run", 16'({bus_a.pass, bus_a.fail_valid, bus_a.fail_mask}), 16'h80);

        $display("[TB] two passes, no settle");
        s0 = samples_b;
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        cyc = 1;
        while (bus_b.done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if ((cyc % 2 == 0) && cyc <= 16)
                check_output("t6_vec_seq", 16'({bus_b.a_o, bus_b.b_o}), 16'((cyc / 2 - 1) % 4));
        end
        check_output("t6_done_cycle", 16'(cyc), 16'd17);
        check_output("t6_samples", 16'(samples_b - s0), 16'd8);
        check_output("t6_pass", 16'(bus_b.pass), 16'h1);
        check_output("t6_mask", 16'({bus_b.fail_valid, bus_b.fail_mask}), 16'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
